banner_cmd_ctrl: RTL and testbench

- Command sequencer between the UART receive FIFO and the BCD banner shift register.
- Pops ASCII bytes from the FIFO and parses them into banner commands: write, start, pause, left, right, faster, slower.
- Assembles written digits into a parallel BCD word with a one-cycle load strobe.
- Schedules scroll steps from the divided-clock tick at a programmable rate. One controller owns all banner sequencing; no separate decoder or serial-to-parallel stage.

---
 rtl/banner_cmd_ctrl.sv | 160 ++++++++++++++++
 tb/tb_banner_cmd_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/banner_cmd_ctrl.sv
// rtl/banner_cmd_ctrl.sv - UART byte parser, digit assembler and scroll-step scheduler for the BCD banner
module banner_cmd_ctrl #(
  parameter int DIGITS        = 6,
  parameter int TIMEOUT_TICKS = 10,
  parameter int DEFAULT_SPEED = 1,
  parameter int MAX_SPEED     = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                rx_empty_i,
  input  logic [7:0]          rx_data_i,
  output logic                rd_data_o,
  input  logic                tick_i,
  output logic                load_tick_o,
  output logic [4*DIGITS-1:0] load_data_o,
  output logic                write_mode_o,
  output logic                scroll_en_o,
  output logic                dir_left_o,
  output logic                shift_tick_o,
  output logic                err_tick_o
);
  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int SW = $clog2(MAX_SPEED + 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t          state_q, state_d;
  logic            pop_q;
  logic [CW-1:0]   digits_q, digits_d;
  logic [DW-1:0]   buf_q, buf_d;
  logic [DW-1:0]   load_data_q, load_data_d;
  logic            load_tick_q, load_tick_d;
  logic [TW-1:0]   to_q, to_d;
  logic [SW-1:0]   speed_q, speed_d;
  logic [SW-1:0]   step_q, step_d;
  logic            scroll_q, scroll_d;
  logic            dir_q, dir_d;
  logic            pop, is_digit, err, shift;
  logic [DW-1:0]   shifted;

  // A pop is never issued in the cycle right after a pop, so the FIFO head has time to advance.
  assign pop      = !rx_empty_i && !pop_q;
  assign is_digit = (rx_data_i >= 8'h30) && (rx_data_i <= 8'h39);
  assign shifted  = (buf_q << 4) | {{(DW-4){1'b0}}, rx_data_i[3:0]};

  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    buf_d       = buf_q;
    load_data_d = load_data_q;
    load_tick_d = 1'b0;
    to_d        = to_q;
    speed_d     = speed_q;
    step_d      = step_q;
    scroll_d    = scroll_q;
    dir_d       = dir_q;
    err         = 1'b0;
    shift       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pop) begin
          case (rx_data_i)
            "w": begin
              state_d  = WRITE;
              digits_d = '0;
              to_d     = '0;
              buf_d    = '0;
            end
            "s": scroll_d = 1'b1;
            "p": scroll_d = 1'b0;
            "l": dir_d = 1'b1;
            "r": dir_d = 1'b0;
            "+": if (speed_q > SW'(1)) speed_d = speed_q - SW'(1);
            "-": if (speed_q < SW'(MAX_SPEED)) speed_d = speed_q + SW'(1);
            8'h0d, 8'h0a: ;
            default: err = 1'b1;
          endcase
        end
      end
      WRITE: begin
        if (pop) begin
          to_d = '0;
          if (is_digit) begin
            buf_d = shifted;
            if (digits_q == CW'(DIGITS - 1)) begin
              load_data_d = shifted;
              load_tick_d = 1'b1;
              digits_d    = '0;
              state_d     = IDLE;
            end else begin
              digits_d = digits_q + CW'(1);
            end
          end else begin
            err     = 1'b1;
            state_d = IDLE;
          end
        end else if (tick_i) begin
          if (to_q == TW'(TIMEOUT_TICKS - 1)) begin
            err     = 1'b1;
            state_d = IDLE;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
      end
    endcase

    // ">=" rather than "==" so a speed drop below the running count fires on the next tick.
    if (scroll_q && state_q == IDLE && tick_i) begin
      if (load_tick_q) begin
        step_d = '0;
      end else if ((step_q + SW'(1)) >= speed_q) begin
        shift  = 1'b1;
        step_d = '0;
      end else begin
        step_d = step_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      pop_q       <= 1'b0;
      digits_q    <= '0;
      buf_q       <= '0;
      load_data_q <= '0;
      load_tick_q <= 1'b0;
      to_q        <= '0;
      speed_q     <= SW'(DEFAULT_SPEED);
      step_q      <= '0;
      scroll_q    <= 1'b0;
      dir_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      pop_q       <= pop;
      digits_q    <= digits_d;
      buf_q       <= buf_d;
      load_data_q <= load_data_d;
      load_tick_q <= load_tick_d;
      to_q        <= to_d;
      speed_q     <= speed_d;
      step_q      <= step_d;
      scroll_q    <= scroll_d;
      dir_q       <= dir_d;
    end
  end

  assign rd_data_o    = pop;
  assign err_tick_o   = err;
  assign shift_tick_o = shift;
  assign load_tick_o  = load_tick_q;
  assign load_data_o  = load_data_q;
  assign write_mode_o = (state_q == WRITE);
  assign scroll_en_o  = scroll_q;
  assign dir_left_o   = dir_q;
endmodule

// File: tb/tb_banner_cmd_ctrl.sv
// tb/tb_banner_cmd_ctrl.sv - scoreboard bench for banner_cmd_ctrl
`timescale 1ns/1ps
module tb_banner_cmd_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_empty = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rd_data;
  logic        tick = 1'b0;
  logic        load_tick;
  logic [23:0] load_data;
  logic        write_mode, scroll_en, dir_left, shift_tick, err_tick;

  always #5 clk = ~clk;

  banner_cmd_ctrl #(
    .DIGITS(6), .TIMEOUT_TICKS(10), .DEFAULT_SPEED(1), .MAX_SPEED(8)
  ) dut (
    .clk_i(clk), .reset_i(reset), .rx_empty_i(rx_empty), .rx_data_i(rx_data),
    .rd_data_o(rd_data), .tick_i(tick), .load_tick_o(load_tick), .load_data_o(load_data),
    .write_mode_o(write_mode), .scroll_en_o(scroll_en), .dir_left_o(dir_left),
    .shift_tick_o(shift_tick), .err_tick_o(err_tick)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [23:0] data;
  } ev_t;

  localparam logic [1:0] K_LOAD = 2'd1, K_ERR = 2'd2, K_SHIFT = 2'd3;

  ev_t        exp_q[$];
  logic [7:0] fifo[$];
  int         checks = 0;
  int         failures = 0;
  int         pops = 0;
  logic       prev_rd = 1'b0;
  logic       drv_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [23:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [1:0] k, input logic [23:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected: got kind=%0d data=0x%0h expected no event", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.data !== d) begin
        failures++;
        $display("FAIL sb_event: got kind=%0d data=0x%0h expected kind=%0d data=0x%0h",
                 k, d, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every strobe the DUT presents is matched against the next expected event.
  always @(negedge clk) begin
    if (!reset) begin
      if (load_tick)  sb_pop(K_LOAD, load_data);
      if (err_tick)   sb_pop(K_ERR, 24'h0);
      if (shift_tick) sb_pop(K_SHIFT, {23'h0, dir_left});
      if (rd_data) begin
        checks++;
        if (prev_rd) begin
          failures++;
          $display("FAIL rd_back_to_back: got rd_data=1 twice expected single-cycle pops");
        end
      end
      prev_rd = rd_data;
    end else begin
      prev_rd = 1'b0;
    end
  end

  task automatic drive_rx();
    rx_empty = (fifo.size() == 0);
    rx_data  = (fifo.size() == 0) ? 8'h00 : fifo[0];
  endtask

  // First-word-fall-through FIFO model.
  always @(posedge clk) begin
    drv_pend = rd_data;
    #1;
    if (drv_pend && fifo.size() > 0) begin
      void'(fifo.pop_front());
      pops++;
    end
    drive_rx();
  end

  task automatic wait_drain();
    int n = 0;
    while (fifo.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fifo.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d bytes left expected 0", fifo.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic send(input string s);
    @(posedge clk);
    #2;
    for (int i = 0; i < s.len(); i++) fifo.push_back(s[i]);
    drive_rx();
    wait_drain();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      repeat (8) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rd_data"},    rd_data,    0);
    check({tag, "_load_tick"},  load_tick,  0);
    check({tag, "_load_data"},  load_data,  0);
    check({tag, "_write_mode"}, write_mode, 0);
    check({tag, "_scroll_en"},  scroll_en,  0);
    check({tag, "_dir_left"},   dir_left,   1);
    check({tag, "_shift_tick"}, shift_tick, 0);
    check({tag, "_err_tick"},   err_tick,   0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    drive_rx();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1 reset = 1'b0;

    pops = 0;
    expect_ev(K_LOAD, 24'h123456);
    send("w123456");
    check("pop_count", pops, 7);
    check("load_data_123456", load_data, 24'h123456);
    check("write_mode_after_load", write_mode, 0);

    send("s");
    check("scroll_en_on", scroll_en, 1);
    check("dir_left_default", dir_left, 1);
    repeat (4) expect_ev(K_SHIFT, 24'h1);
    ticks(4);
    send("p");
    check("scroll_en_off", scroll_en, 0);
    ticks(3);
    send("r");
    send("s");
    check("dir_left_right", dir_left, 0);
    repeat (3) expect_ev(K_SHIFT, 24'h0);
    ticks(3);

    send("---s");
    repeat (2) expect_ev(K_SHIFT, 24'h0);
    ticks(8);
    send("----------");
    repeat (2) expect_ev(K_SHIFT, 24'h0);
    ticks(16);
    send("++++++++++");
    repeat (3) expect_ev(K_SHIFT, 24'h0);
    ticks(3);
    send("p");

    expect_ev(K_ERR, 24'h0);
    send("w12a");
    check("write_mode_after_bad", write_mode, 0);
    check("load_data_after_bad", load_data, 24'h123456);

    send("w12");
    check("write_mode_pending", write_mode, 1);
    ticks(9);
    check("write_mode_tick9", write_mode, 1);
    expect_ev(K_ERR, 24'h0);
    ticks(1);
    check("write_mode_timeout", write_mode, 0);

    send("w1");
    ticks(9);
    send("2");
    ticks(9);
    check("write_mode_restart", write_mode, 1);
    expect_ev(K_ERR, 24'h0);
    ticks(1);
    check("write_mode_timeout2", write_mode, 0);
    check("load_data_after_timeout", load_data, 24'h123456);

    send("--");
    send("w123");
    check("write_mode_before_reset", write_mode, 1);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("midreset");
    @(posedge clk); #1 reset = 1'b0;

    expect_ev(K_LOAD, 24'h654321);
    send("w654321");
    check("load_data_654321", load_data, 24'h654321);
    send("s");
    repeat (2) expect_ev(K_SHIFT, 24'h1);
    ticks(2);

    repeat (5) @(negedge clk);
    check("sb_leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
